// File: rtl/seg_display_scanner.sv
// Eight-digit multiplexed seven-segment scanner with a one-entry load buffer and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_display_scanner #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    input  logic        sel,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          tick;
    logic          wrap;
    logic          capture;

    logic          pend_valid;
    logic          pend_sel;
    logic [31:0]   pend_word;
    logic          disp_sel;
    logic [31:0]   disp_word;

    logic [31:0]   disp_shifted;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign tick         = (cnt == CNT_LAST);
    assign wrap         = tick && (idx == 3'd7);
    assign load_ready   = ~pend_valid;
    assign capture      = load_valid && ~pend_valid;
    assign disp_shifted = disp_word >> {idx, 2'b00};
    assign nibble       = disp_shifted[3:0];

`ifdef SEG_LZ_BLANK_EN
    logic [2:0] top_digit;

    // NOTE: default assigned before the loop so no path leaves top_digit unassigned (no latch).
    always_comb begin
        top_digit = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (disp_word[4*i +: 4] != 4'h0) top_digit = 3'(i);
        end
    end

    assign blank = (idx > top_digit);
`else
    assign blank = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) idx <= idx + 3'd1;
        end
    end

    // Capture and transfer are exclusive: transfer needs a full buffer, capture an empty one,
    // so a capture on the wrap edge naturally waits for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_sel   <= 1'b0;
            pend_word  <= '0;
            disp_sel   <= 1'b0;
            disp_word  <= '0;
        end else if (wrap && pend_valid) begin
            disp_word  <= pend_word;
            disp_sel   <= pend_sel;
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_sel   <= sel;
            pend_word  <= sel ? data_b : data_a;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= blank ? 8'hFF : ~(8'h01 << idx);
            seg        <= blank ? 7'h7F : glyph(nibble);
            dp         <= ~((idx == 3'd0) && disp_sel);
            frame_done <= wrap;
        end
    end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port data_a, input, 32, first candidate word (processor register-file tap).
REQ-005 SHALL have port data_b, input, 32, second candidate word.
REQ-006 SHALL have port sel, input, 1, source select: 0 = data_a, 1 = data_b; sampled with load_valid.
REQ-007 SHALL have port load_valid, input, 1, request to capture the selected word.
REQ-008 SHALL have port load_ready, output, 1, high when a capture is accepted this cycle.
REQ-009 SHALL have port an, output, 8, digit enables, active-low, bit i = digit i.
REQ-010 SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1, decimal point, active-low.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at end of each 8-digit frame.

Function
REQ-013 SHALL run a prescaler counting 0..SCAN_DIV-1, wrapping to 0; tick = (count == SCAN_DIV-1).
REQ-014 SHALL advance digit index idx (0..7) on each tick, wrapping 7 -> 0.
REQ-015 SHALL accept a capture on a rising edge where load_valid && load_ready, storing {sel, selected word} into a one-entry pending buffer.
REQ-016 SHALL drive load_ready = 1 iff the pending buffer is empty.
REQ-017 SHALL transfer pending into the display register on the tick where idx wraps 7 -> 0, and empty the buffer on the same edge; no transfer if the buffer was empty.
REQ-018 SHALL, when a capture and a wrap tick coincide with an empty buffer, fill the buffer and defer display to the next frame.
REQ-019 SHALL never change the display register except at a frame wrap (no tearing).
REQ-020 SHALL register an, seg, dp with one-cycle latency from idx and display register.
REQ-021 SHALL drive an = ~(8'b1 << idx) and seg = hex glyph of display[4*idx+3 : 4*idx].
REQ-022 SHALL use glyphs 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E.
REQ-023 SHALL drive dp = 0 only when idx = 0 and the displayed word came from data_b; otherwise 1.
REQ-024 SHALL pulse frame_done for exactly one cycle, on the cycle after the wrap edge.

Reset
REQ-025 SHALL, while reset = 0, immediately force an = 0xFF, seg = 0x7F, dp = 1, frame_done = 0.
REQ-026 SHALL, while reset = 0, clear prescaler, idx, display register (value 0, source a) and pending buffer (load_ready = 1).
REQ-027 SHALL, on reset asserted mid-frame or with a pending word, discard the pending word.
REQ-028 SHALL drive an = 0xFE, seg = 0x40 on the first edge after reset release.

Configuration
REQ-029 SHALL, with macro SEG_LZ_BLANK_EN defined, blank leading zeros: digits above the most significant nonzero nibble drive an bit high and seg = 0x7F; digit 0 is never blanked.
REQ-030 SHALL, without SEG_LZ_BLANK_EN, display all eight digits unconditionally.

Verification (SCAN_DIV = 4)
REQ-031 SHALL check reset: reset low mid-scan -> an = 0xFF, seg = 0x7F, load_ready = 1 same cycle; release -> an = 0xFE, seg = 0x40 next edge.
REQ-032 SHALL check scan: idle 40 cycles -> an steps FE, FD, FB ... 7F, FE every 4 cycles; frame_done pulses every 32 cycles.
REQ-033 SHALL check load: data_a = 0x89ABCDEF, sel = 0, load_valid 1 cycle -> load_ready 0 until wrap; next frame digit 0 = 0x0E, digit 7 = 0x00; dp stays 1.
REQ-034 SHALL check backpressure: second load_valid while buffer full (data_b = 0x12345678, sel = 1) -> not accepted; re-presented after wrap -> shown following frame with dp = 0 on digit 0.
REQ-035 SHALL check coincidence: capture on the wrap-tick edge -> value appears one frame later, not immediately.
REQ-036 SHALL check blanking: word 0x000000A5 -> with SEG_LZ_BLANK_EN an bits 7..2 never low; without it, digits 7..2 show 0x40.
